// File: rtl/score_argmax7.sv
// score_argmax7: streaming signed argmax over frames of N scores, one result per frame.
// Define ARGMAX_TIE_LAST_EN so that the latest of several equal maxima wins.
module score_argmax7 #(
    parameter int WIDTH = 12,
    parameter int N     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_score,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_max,
    output logic [2:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    localparam logic [3:0] LAST = 4'(N - 1);

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] maxReg;
    logic [2:0]       idxReg;
    logic [3:0]       count;
    logic             accept;
    logic             takeNew;

    // A flush wins over a same-cycle beat, so only unflushed handshakes count as accepts.
    assign accept = in_valid && in_ready && !flush;

`ifdef ARGMAX_TIE_LAST_EN
    assign takeNew = $signed(in_score) >= $signed(maxReg);
`else
    assign takeNew = $signed(in_score) > $signed(maxReg);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (!flush && in_valid) begin
                    nextState = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (flush) begin
                    nextState = IDLE;
                end else if (in_valid && (count == LAST)) begin
                    nextState = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Running max/index/count; count doubles as the arrival position of the next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            maxReg <= '0;
            idxReg <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        count <= '0;
                    end else if (accept) begin
                        maxReg <= in_score;
                        idxReg <= 3'd0;
                        count  <= 4'd1;
                    end
                end
                ACC: begin
                    if (flush) begin
                        count <= '0;
                    end else if (accept) begin
                        if (takeNew) begin
                            maxReg <= in_score;
                            idxReg <= count[2:0];
                        end
                        count <= count + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        count <= '0;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign out_max = maxReg;
    assign out_idx = idxReg;

endmodule

// File: tb/tb_score_argmax7.sv
// Scoreboard bench for score_argmax7: driver feeds frames into a reference model,
// a separate monitor pops expected results whenever an output beat transfers.
module tb_score_argmax7;

    localparam int WIDTH = 12;
    localparam int N     = 7;

    typedef struct {
        int       mx;
        logic [2:0] ix;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_score = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] out_max;
    logic [2:0]       out_idx;
    logic             out_valid;
    logic             out_ready = 1'b0;

    int   checks   = 0;
    int   failures = 0;
    int   frameQ[$];
    exp_t sbQ[$];
    exp_t monExp;
    logic modelBusy     = 1'b0;
    logic randomReady   = 1'b0;
    logic outReadyFixed = 1'b1;

    score_argmax7 #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_score(in_score),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_max(out_max),
        .out_idx(out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: the largest value of the frame, then its first (or last) occurrence.
    function automatic exp_t refArgmax(input int f[$]);
        exp_t r;
        int   best;
        logic found;
        best  = f[0];
        found = 1'b0;
        foreach (f[i]) if (f[i] > best) best = f[i];
        r.mx = best;
        r.ix = 3'd0;
        foreach (f[i]) begin
            if (f[i] == best) begin
`ifdef ARGMAX_TIE_LAST_EN
                r.ix = 3'(i);
`else
                if (!found) begin
                    r.ix  = 3'(i);
                    found = 1'b1;
                end
`endif
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic v, input int s, input logic f);
        @(posedge clk);
        #1;
        checkOutput("in_ready", in_ready, !modelBusy);
        checkOutput("out_valid", out_valid, modelBusy);
        in_valid  = v;
        in_score  = WIDTH'(s);
        flush     = f;
        out_ready = randomReady ? 1'($urandom_range(0, 1)) : outReadyFixed;
        @(negedge clk);
        if (!modelBusy) begin
            if (f) begin
                frameQ.delete();
            end else if (v) begin
                frameQ.push_back(s);
                if (frameQ.size() == N) begin
                    sbQ.push_back(refArgmax(frameQ));
                    frameQ.delete();
                    modelBusy = 1'b1;
                end
            end
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        frameQ.delete();
        sbQ.delete();
        modelBusy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_max", $signed(out_max), 0);
        checkOutput("rst_out_idx", out_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic sendFrame(input int s0, input int s1, input int s2, input int s3,
                             input int s4, input int s5, input int s6);
        int v[7];
        v = '{s0, s1, s2, s3, s4, s5, s6};
        for (int i = 0; i < N; i++) applyStimulus(1'b1, v[i], 1'b0);
    endtask

    // Monitor: every output transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat: got max=%0d idx=%0d expected no beat",
                         $signed(out_max), out_idx);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("out_max", $signed(out_max), monExp.mx);
                checkOutput("out_idx", out_idx, monExp.ix);
            end
            modelBusy = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        // Mixed values with a tie at the maximum.
        outReadyFixed = 1'b1;
        sendFrame(5, -3, 17, 2, 17, 0, -2048);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);

        // All scores at the most negative value.
        for (int i = 0; i < N; i++) applyStimulus(1'b1, -2048, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);

        // Backpressure: the held result must not move, and flush in OUT is ignored.
        outReadyFixed = 1'b0;
        sendFrame(2047, -1, -7, 100, 2046, -2048, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 55, (i == 3));
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_max", $signed(out_max), 2047);
            checkOutput("hold_out_idx", out_idx, 0);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        outReadyFixed = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);

        // Flush a partial frame, with a beat offered in the same cycle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 9, 1'b0);
        applyStimulus(1'b1, 9, 1'b1);
        sendFrame(1, 2, 3, 4, 5, 6, 7);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);

        // Reset mid-frame, then a fresh frame.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 500 + i, 1'b0);
        doReset();
        sendFrame(0, 0, 0, 100, 0, 0, 0);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);

        // Reset while a result is pending in OUT.
        outReadyFixed = 1'b0;
        sendFrame(3, 1, 4, 1, 5, 9, 2);
        applyStimulus(1'b0, 0, 1'b0);
        doReset();
        outReadyFixed = 1'b1;

        // Random gaps, flushes, back-to-back frames and random backpressure.
        randomReady = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            int   s;
            logic v;
            logic f;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 1) s = int'($urandom_range(0, 4095)) - 2048;
            else s = int'($urandom_range(0, 4)) - 2;
            applyStimulus(v, s, f);
        end

        // Drain whatever is still pending.
        randomReady   = 1'b0;
        outReadyFixed = 1'b1;
        for (int c = 0; c < 50 && (sbQ.size() != 0 || modelBusy); c++) applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("drain_empty", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_argmax7.md
SCORE_ARGMAX7 -- requirements
Module: score_argmax7

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the signed score width in bits.
REQ-002 The block SHALL have parameter N, default 7, giving the number of scores per frame (range 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_score, input, WIDTH bits: the signed candidate score.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_score is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_score this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: discards the partial frame.
REQ-009 The block SHALL have port out_max, output, WIDTH bits: the signed maximum of the frame.
REQ-010 The block SHALL have port out_idx, output, 3 bits: the arrival position (0..N-1) of the winning score within the frame.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_max and out_idx are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.

Function
REQ-013 An input beat SHALL transfer on a cycle where in_valid and in_ready are both high.
REQ-014 An output beat SHALL transfer on a cycle where out_valid and out_ready are both high.
REQ-015 The FSM SHALL have states IDLE, ACC and OUT, and SHALL leave reset in IDLE.
REQ-016 In IDLE and ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 In OUT, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-018 An accept in IDLE SHALL load the running max with in_score, set the running index to 0, set the count to 1, and move to ACC.
REQ-019 An accept in ACC at position k SHALL replace the running max and set index=k when in_score > max (signed compare); otherwise it SHALL hold max and index.
REQ-020 When the accept is beat N-1, the block SHALL move to OUT on the next edge, so out_valid rises exactly one cycle after the Nth accept.
REQ-021 out_max and out_idx SHALL stay stable throughout OUT until the output transfer.
REQ-022 An output transfer SHALL return the FSM to IDLE, with in_ready high the following cycle.
REQ-023 The comparison SHALL be full-width two's-complement, with no saturation, truncation or widening of out_max.
REQ-024 flush high in IDLE or ACC SHALL clear the count, return the FSM to IDLE, and ignore any same-cycle input beat.
REQ-025 flush high in OUT SHALL have no effect; the held result is not lost.
REQ-026 in_valid low in ACC SHALL hold all state indefinitely, with no timeout.
REQ-027 out_ready high outside OUT SHALL have no effect.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE and clear the count to 0.
REQ-029 rst SHALL clear out_max and out_idx to 0 and out_valid to 0.
REQ-030 rst SHALL set in_ready to 1 from the first cycle after reset.
REQ-031 rst SHALL take priority over flush and over both handshakes.
REQ-032 Reset mid-frame or during OUT SHALL discard the partial frame or the pending result, with no output beat.

Configuration
REQ-033 The compile-time feature SHALL be controlled by the macro ARGMAX_TIE_LAST_EN.
REQ-034 With ARGMAX_TIE_LAST_EN undefined, the ACC update SHALL use strict > comparison, so on ties the earliest position wins.
REQ-035 With ARGMAX_TIE_LAST_EN defined, the ACC update SHALL use >= comparison, so on ties the latest position wins; no other behaviour SHALL change.

Verification
REQ-036 Scores 5,-3,17,2,17,0,-2048 with out_ready=1 SHALL produce out_max=17 and out_idx=2, or out_idx=4 with ARGMAX_TIE_LAST_EN, with out_valid one cycle after the 7th accept.
REQ-037 Seven scores all -2048 SHALL produce out_max=-2048 and out_idx=0, or out_idx=6 with ARGMAX_TIE_LAST_EN.
REQ-038 Scores 2047,-1,... with 2047 at position 0, and out_ready held 0 for 10 cycles, SHALL keep out_valid=1, out_max=2047, out_idx=0 and in_ready=0 throughout, then return to IDLE one cycle after out_ready=1.
REQ-039 Three beats 9,9,9 then flush, then frame 1,2,3,4,5,6,7 SHALL produce out_max=7 and out_idx=6.
REQ-040 rst asserted after beat 4 of a frame, then a full frame of 0,0,0,100,0,0,0, SHALL produce exactly one output beat: out_max=100, out_idx=3.
REQ-041 Random in_valid gaps with back-to-back frames and random out_ready SHALL match a scoreboard reference model with no dropped or duplicated beats.
